// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_frame_rx
//  Purpose  : Oversampling receiver for start/data(LSB first)/stop frames
//             with a valid/ack output handshake. Optional even parity bit
//             enabled by defining RX_PARITY_EN.
//  Revision : 1.0  initial release
// ============================================================================
module serial_frame_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Sample_Enable,
    input  logic                 SerialIn,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef RX_PARITY_EN
    output logic                 parity_err,
    output logic [2:0]           st
`else
    output logic [1:0]           st
`endif
);

    localparam int c_TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int c_BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [c_TICK_W-1:0] c_TICK_MID  = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);

`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_START  = 3'b001,
        S_DATA   = 3'b010,
        S_STOP   = 3'b011,
        S_PARITY = 3'b100
    } state_t;
    localparam state_t c_AFTER_DATA = S_PARITY;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_DATA  = 2'b10,
        S_STOP  = 2'b11
    } state_t;
    localparam state_t c_AFTER_DATA = S_STOP;
`endif

    state_t                r_state;
    logic                  r_sync1;
    logic                  r_rx;
    logic [c_TICK_W-1:0]   r_tick;
    logic [c_BIT_W-1:0]    r_bit;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  w_shift_next;
    logic                  w_par_ok;

    // New bits enter at the MSB so the first (LSB) bit ends up at bit 0.
    generate
        if (DATA_BITS == 1) begin : g_shift_one
            assign w_shift_next = r_rx;
        end else begin : g_shift_multi
            assign w_shift_next = {r_rx, r_shift[DATA_BITS-1:1]};
        end
    endgenerate

`ifdef RX_PARITY_EN
    logic r_par;
    assign w_par_ok = ((^r_shift) == r_par);
`else
    assign w_par_ok = 1'b1;
`endif

    assign st = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sync1    <= 1'b1;
            r_rx       <= 1'b1;
            r_tick     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef RX_PARITY_EN
            r_par      <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            r_sync1   <= SerialIn;
            r_rx      <= r_sync1;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (rd_ack) begin
                data_valid <= 1'b0;
            end

            if (Sample_Enable) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_rx) begin
                            r_state <= S_START;
                            r_tick  <= '0;
                        end
                    end
                    S_START: begin
                        if (r_tick == c_TICK_MID) begin
                            if (!r_rx) begin
                                r_state <= S_DATA;
                                r_tick  <= '0;
                                r_bit   <= '0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (r_tick == c_TICK_LAST) begin
                            r_shift <= w_shift_next;
                            r_tick  <= '0;
                            r_bit   <= r_bit + 1'b1;
                            if (r_bit == c_BIT_LAST) begin
                                r_state <= c_AFTER_DATA;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
`ifdef RX_PARITY_EN
                    S_PARITY: begin
                        if (r_tick == c_TICK_LAST) begin
                            r_par   <= r_rx;
                            r_tick  <= '0;
                            r_state <= S_STOP;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
`endif
                    S_STOP: begin
                        if (r_tick == c_TICK_LAST) begin
                            r_state <= S_IDLE;
                            r_tick  <= '0;
                            if (!r_rx) begin
                                frame_err <= 1'b1;
                            end else if (w_par_ok) begin
                                // A same-cycle ack consumes the old word, so no overrun.
                                data_out   <= r_shift;
                                data_valid <= 1'b1;
                                overrun    <= data_valid & ~rd_ack;
                            end
`ifdef RX_PARITY_EN
                            else begin
                                parity_err <= 1'b1;
                            end
`endif
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_frame_rx
//  Purpose  : Directed self-checking bench for serial_frame_rx (defaults).
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_frame_rx;

    localparam int CLKS_PER_BIT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Sample_Enable = 1'b0;
    logic       SerialIn = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
`ifdef RX_PARITY_EN
    logic       parity_err;
    logic [2:0] st;
`else
    logic [1:0] st;
`endif

    int tests = 0;
    int fails = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    int dv_rise = 0;
    logic dv_prev = 1'b0;

    serial_frame_rx #(.DATA_BITS(8), .OVERSAMPLE(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Sample_Enable(Sample_Enable),
        .SerialIn     (SerialIn),
        .rd_ack       (rd_ack),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .frame_err    (frame_err),
        .overrun      (overrun),
`ifdef RX_PARITY_EN
        .parity_err   (parity_err),
`endif
        .st           (st)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            Sample_Enable = 1'b1;
            @(negedge clk);
            Sample_Enable = 1'b0;
        end
    end

    // Pulse and edge counters, sampled just after each active edge.
    always @(posedge clk) begin
        #1;
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
`ifdef RX_PARITY_EN
        if (parity_err) pe_cnt++;
`endif
        if (data_valid && !dv_prev) dv_rise++;
        dv_prev = data_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_counts();
        fe_cnt = 0; ov_cnt = 0; pe_cnt = 0; dv_rise = 0;
    endtask

    task automatic drive_bit(input logic b);
        SerialIn = b;
        repeat (CLKS_PER_BIT) @(negedge clk);
    endtask

    task automatic idle(input int n);
        SerialIn = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop_b);
        SerialIn = 1'b1;
    endtask

    task automatic pulse_ack();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    // Raise rd_ack for exactly the clock whose tick samples the stop bit.
    task automatic ack_at_stop(output bit hit);
        int ticks = 0;
        hit = 1'b0;
        for (int n = 0; n < 600 && !hit; n++) begin
            @(negedge clk);
            #1;
            if (st == 3 && Sample_Enable) begin
                ticks++;
                if (ticks == 4) begin
                    rd_ack = 1'b1;
                    @(negedge clk);
                    rd_ack = 1'b0;
                    hit = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (st !== 0) begin fails++; $display("FAIL reset_st: got %0d expected 0", st); end
        tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset_data: got %0h expected 00", data_out); end
        tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
        tests++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin fails++; $display("FAIL reset_pulses: got fe=%b ov=%b expected 0 0", frame_err, overrun); end
        rst_n = 1'b1;
        idle(8);
    endtask

    task automatic test_good_frame();
        clear_counts();
        send_frame(8'hA5, 1'b1);
        idle(8);
        tests++; if (data_valid !== 1'b1) begin fails++; $display("FAIL a5_valid: got %b expected 1", data_valid); end
        tests++; if (data_out !== 8'hA5) begin fails++; $display("FAIL a5_data: got %0h expected a5", data_out); end
        tests++; if (fe_cnt !== 0) begin fails++; $display("FAIL a5_frame_err: got %0d pulses expected 0", fe_cnt); end
        tests++; if (st !== 0) begin fails++; $display("FAIL a5_st: got %0d expected 0", st); end
        pulse_ack();
        tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL a5_ack: got valid=%b expected 0", data_valid); end
        pulse_ack();
        tests++; if (data_valid !== 1'b0 || data_out !== 8'hA5) begin fails++; $display("FAIL idle_ack: got valid=%b data=%0h expected 0 a5", data_valid, data_out); end
    endtask

    task automatic test_glitch();
        clear_counts();
        SerialIn = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        tests++; if (st !== 0) begin fails++; $display("FAIL glitch_st: got %0d expected 0", st); end
        tests++; if (dv_rise !== 0 || data_valid !== 1'b0) begin fails++; $display("FAIL glitch_valid: got rises=%0d valid=%b expected 0 0", dv_rise, data_valid); end
        tests++; if (fe_cnt !== 0 || ov_cnt !== 0) begin fails++; $display("FAIL glitch_pulses: got fe=%0d ov=%0d expected 0 0", fe_cnt, ov_cnt); end
    endtask

    task automatic test_frame_err();
        clear_counts();
        send_frame(8'h3C, 1'b0);
        idle(40);
        tests++; if (fe_cnt !== 1) begin fails++; $display("FAIL ferr_pulse: got %0d cycles expected 1", fe_cnt); end
        tests++; if (data_valid !== 1'b0 || dv_rise !== 0) begin fails++; $display("FAIL ferr_valid: got valid=%b rises=%0d expected 0 0", data_valid, dv_rise); end
        tests++; if (data_out !== 8'hA5) begin fails++; $display("FAIL ferr_data: got %0h expected a5", data_out); end
        tests++; if (st !== 0) begin fails++; $display("FAIL ferr_st: got %0d expected 0", st); end
    endtask

    task automatic test_overrun();
        clear_counts();
        send_frame(8'h11, 1'b1);
        idle(8);
        tests++; if (data_valid !== 1'b1 || data_out !== 8'h11) begin fails++; $display("FAIL ovr_first: got valid=%b data=%0h expected 1 11", data_valid, data_out); end
        send_frame(8'h22, 1'b1);
        idle(8);
        tests++; if (ov_cnt !== 1) begin fails++; $display("FAIL ovr_pulse: got %0d cycles expected 1", ov_cnt); end
        tests++; if (data_valid !== 1'b1 || data_out !== 8'h22) begin fails++; $display("FAIL ovr_second: got valid=%b data=%0h expected 1 22", data_valid, data_out); end
        pulse_ack();
        tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL ovr_ack: got valid=%b expected 0", data_valid); end
    endtask

    task automatic test_back_to_back_ack();
        bit hit;
        clear_counts();
        send_frame(8'h66, 1'b1);
        idle(8);
        tests++; if (data_valid !== 1'b1 || data_out !== 8'h66) begin fails++; $display("FAIL b2b_first: got valid=%b data=%0h expected 1 66", data_valid, data_out); end
        fork
            send_frame(8'h77, 1'b1);
            ack_at_stop(hit);
        join
        idle(8);
        tests++; if (hit !== 1'b1) begin fails++; $display("FAIL b2b_stop_seen: got %b expected 1", hit); end
        tests++; if (data_valid !== 1'b1 || data_out !== 8'h77) begin fails++; $display("FAIL b2b_second: got valid=%b data=%0h expected 1 77", data_valid, data_out); end
        tests++; if (ov_cnt !== 0) begin fails++; $display("FAIL b2b_overrun: got %0d cycles expected 0", ov_cnt); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        d = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        SerialIn = d[4];
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if (st !== 0) begin fails++; $display("FAIL mid_rst_st: got %0d expected 0", st); end
        tests++; if (data_out !== 8'h00 || data_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_out: got data=%0h valid=%b expected 00 0", data_out, data_valid); end
        tests++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin fails++; $display("FAIL mid_rst_pulses: got fe=%b ov=%b expected 0 0", frame_err, overrun); end
        SerialIn = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idle(40);
        clear_counts();
        send_frame(8'h5A, 1'b1);
        idle(8);
        tests++; if (data_valid !== 1'b1 || data_out !== 8'h5A) begin fails++; $display("FAIL post_rst_frame: got valid=%b data=%0h expected 1 5a", data_valid, data_out); end
        tests++; if (fe_cnt !== 0 || ov_cnt !== 0) begin fails++; $display("FAIL post_rst_pulses: got fe=%0d ov=%0d expected 0 0", fe_cnt, ov_cnt); end
        pulse_ack();
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity();
        clear_counts();
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(i == 0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        idle(8);
        tests++; if (pe_cnt !== 1) begin fails++; $display("FAIL par_bad_pulse: got %0d cycles expected 1", pe_cnt); end
        tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL par_bad_valid: got %b expected 0", data_valid); end
        send_frame(8'h01, 1'b1);
        idle(8);
        tests++; if (data_valid !== 1'b1 || data_out !== 8'h01) begin fails++; $display("FAIL par_good: got valid=%b data=%0h expected 1 01", data_valid, data_out); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back_ack();
        test_reset_midframe();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Receive end of the shift-pulse serial link. Recovers frames the transmit-side pulse generator and shift register put on the line: start bit (0), DATA_BITS data bits LSB first, stop bit (1).
- Oversamples the line on Sample_Enable ticks and checks start and stop bits.
- Presents each received word on a valid/ack handshake to the consuming logic.

Parameters:
- DATA_BITS, 8, data bits per frame (1..16).
- OVERSAMPLE, 4, Sample_Enable ticks per bit period (even, >=2).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- Sample_Enable  input  1  single-cycle tick at OVERSAMPLE x bit rate.
- SerialIn  input  1  serial line, idles high, asynchronous to clk.
- rd_ack  input  1  consumer has taken data_out.
- data_out  output  DATA_BITS  last good received word.
- data_valid  output  1  data_out holds an unacknowledged word.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: unacknowledged word overwritten.
- st  output  2  current state, debug mirror.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE (2'b00).
  - Synchroniser flops = 1.
  - data_out = 0; data_valid, frame_err and overrun = 0.
  - Tick, bit and shift counters/registers = 0.
- Reset mid-frame aborts the frame with no pulses.
- Synchroniser: SerialIn passes through two flops, giving 2 clk of latency. All sampling uses the synchronised value `rx`.
- The FSM advances only on cycles with Sample_Enable=1; otherwise it holds. tick_cnt is $clog2(OVERSAMPLE) bits wide.
- IDLE (00): on a tick with rx=0, go to START with tick_cnt=0.
- START (01), on each tick:
  - When tick_cnt == OVERSAMPLE/2-1 (mid start bit): rx=0 → go to DATA with tick_cnt=0 and bit_cnt=0; rx=1 → false start, go to IDLE with no pulse.
  - Otherwise tick_cnt+1.
- DATA (10), on each tick:
  - When tick_cnt == OVERSAMPLE-1: shift rx into the MSB of the shift register (shift right, so the word comes out LSB-first), set tick_cnt=0, bit_cnt+1.
  - After the DATA_BITS-th sample, go to STOP.
- STOP (11): on the tick where tick_cnt == OVERSAMPLE-1:
  - rx=1 → data_out <= shift register and data_valid <= 1, effective the next clk edge.
  - rx=0 → frame_err pulses for exactly one clk; data_out and data_valid are unchanged.
  - Either way, go to IDLE.
- Latency: data_valid rises 1 clk after the clock edge of the stop-sample tick.
- Handshake:
  - data_valid stays high until a cycle with rd_ack=1, and falls the following edge.
  - rd_ack while data_valid=0 is ignored.
- Overrun: a good frame completes while data_valid=1 and rd_ack=0. Then:
  - data_out takes the new word.
  - data_valid stays 1.
  - overrun pulses for one clk.
- Simultaneous completion and rd_ack: the ack consumes the old word, the new word loads, data_valid stays 1, and there is no overrun.
- The FSM never stalls on the consumer. A new start bit is accepted in IDLE regardless of data_valid.

Optional Feature:
- Macro: RX_PARITY_EN.
- With the macro defined:
  - Adds output parity_err (1 bit). Adds state PARITY, so st widens to 3 bits, with PARITY = 3'b100.
  - PARITY is entered after DATA and samples one even-parity bit, then goes to STOP.
  - A mismatch pulses parity_err for one clk at the stop-sample edge, provided the stop bit is good; the word is discarded (data_valid unchanged, no overrun).
  - A bad stop bit reports only frame_err.
- Without the macro: no parity bit, no parity_err port, and st stays 2 bits.

Test Plan:
- Defaults, Sample_Enable every 4th clk: send frame 0xA5 (line 0, 1,0,1,0,0,1,0,1, 1) → data_valid=1 with data_out=0xA5; frame_err=0; st returns to 00.
- Line low for 1 tick then high from IDLE (glitch) → false start; st returns to 00; no data_valid, frame_err or overrun activity.
- Frame 0x3C with stop bit driven 0 → frame_err high for 1 clk; data_valid stays 0; data_out keeps its prior value.
- Frames 0x11 then 0x22, rd_ack held 0 → after the second frame: overrun pulses once, data_out=0x22, data_valid=1. Pulse rd_ack → data_valid=0 one clk later.
- Assert rd_ack on the same clk that frame 0x77 completes while 0x66 is pending → data_out=0x77, data_valid=1, overrun=0.
- rst_n low during bit 4 of a frame → all outputs 0 and st=00 immediately. After release, a clean frame 0x5A is received correctly.
- With RX_PARITY_EN: frame 0x01 with parity bit 0 → parity_err pulse, data_valid=0. Same frame with parity bit 1 → data_valid=1, data_out=0x01.
